stopwatch_ctrl: RTL and testbench

//  Sequencing controller for the stopwatch datapath. Turns start/stop, lap and clear

---
 rtl/stopwatch_pkg.sv | 23 ++
 rtl/stopwatch_ctrl_bcd_counter2.sv | 28 ++
 rtl/stopwatch_ctrl.sv | 101 ++++++++++
 tb/tb_stopwatch_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller.
// The BCD increment helper lives here so the counter and any future users agree on the digit rules.
package stopwatch_pkg;

    typedef enum logic [1:0] {IDLE, RUN, LAP, STOP} sw_state_t;

    localparam logic [7:0] BCD_MAX   = 8'h99;
    localparam logic [3:0] DIGIT_MAX = 4'd9;

    // Next 2-digit BCD value; 99 rolls to 00
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v == BCD_MAX) begin
            r = 8'h00;
        end else if (v[3:0] == DIGIT_MAX) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_bcd_counter2.sv
// Two-digit BCD up-counter; clr beats en, carry_out pulses for one cycle on the 99 -> 00 roll.
module bcd_counter2
    import stopwatch_pkg::*;
(
    input  logic       clk,
    input  logic       nrst,
    input  logic       en,
    input  logic       clr,
    output logic [7:0] q,
    output logic       carry_out
);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            q         <= 8'h00;
            carry_out <= 1'b0;
        end else if (clr) begin
            q         <= 8'h00;
            carry_out <= 1'b0;
        end else if (en) begin
            q         <= bcd_inc(q);
            carry_out <= (q == BCD_MAX);
        end else begin
            carry_out <= 1'b0;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing: run/pause/lap FSM, seconds prescaler, lap-freeze register, display mux.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       start_stop,
    input  logic       lap,
    input  logic       clear,
    output logic [7:0] num,
    output logic       running,
    output logic       lap_active,
    output logic       wrapped
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    sw_state_t     state;
    sw_state_t     state_nxt;
    logic          lap_capture;
    logic [PW-1:0] presc;
    logic          counting;
    logic          tick;
    logic [7:0]    count;
    logic [7:0]    lap_reg;

    assign counting = (state == RUN) || (state == LAP);
    assign tick     = counting && (presc == PRESC_LAST);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Pulse priority: clear, then start_stop, then lap
    always_comb begin
        state_nxt   = state;
        lap_capture = 1'b0;
        if (clear) begin
            state_nxt = IDLE;
        end else if (start_stop) begin
            case (state)
                IDLE:    state_nxt = RUN;
                RUN:     state_nxt = STOP;
                LAP:     state_nxt = STOP;
                STOP:    state_nxt = RUN;
                default: state_nxt = IDLE;
            endcase
        end else if (lap) begin
            case (state)
                RUN: begin
                    state_nxt   = LAP;
                    lap_capture = 1'b1;
                end
                LAP:     state_nxt = RUN;
                default: state_nxt = state;
            endcase
        end
    end

    // Holds while stopped so a resume finishes the partial second
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            presc <= '0;
        end else if (clear) begin
            presc <= '0;
        end else if (counting) begin
            presc <= (presc == PRESC_LAST) ? '0 : presc + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            lap_reg <= 8'h00;
        end else if (clear) begin
            lap_reg <= 8'h00;
        end else if (lap_capture) begin
            lap_reg <= count;
        end
    end

    bcd_counter2 u_count (
        .clk       (clk),
        .nrst      (nrst),
        .en        (tick),
        .clr       (clear),
        .q         (count),
        .carry_out (wrapped)
    );

    assign num        = (state == LAP) ? lap_reg : count;
    assign running    = counting;
    assign lap_active = (state == LAP);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with an integer-seconds reference model checked every cycle.
module tb_stopwatch_ctrl;

    localparam int TICK_DIV = 4;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_LAP  = 2;
    localparam int M_STOP = 3;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       start_stop = 1'b0;
    logic       lap = 1'b0;
    logic       clear = 1'b0;
    logic [7:0] num;
    logic       running;
    logic       lap_active;
    logic       wrapped;

    int vectors = 0;
    int miscompares = 0;

    int m_mode;
    int m_secs;
    int m_lap;
    int m_presc;
    bit m_wrap;
    bit m_tick;

    stopwatch_ctrl #(.TICK_DIV(TICK_DIV)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .start_stop (start_stop),
        .lap        (lap),
        .clear      (clear),
        .num        (num),
        .running    (running),
        .lap_active (lap_active),
        .wrapped    (wrapped)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) * 16) + (v % 10));
    endfunction

    // Reference: seconds as a plain integer, mode as a small number
    assign m_tick = (m_mode == M_RUN || m_mode == M_LAP) && (m_presc == TICK_DIV - 1);

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            m_mode <= M_IDLE; m_secs <= 0; m_lap <= 0; m_presc <= 0; m_wrap <= 1'b0;
        end else if (clear) begin
            m_mode <= M_IDLE; m_secs <= 0; m_lap <= 0; m_presc <= 0; m_wrap <= 1'b0;
        end else begin
            if (m_mode == M_RUN || m_mode == M_LAP)
                m_presc <= (m_presc + 1) % TICK_DIV;
            if (m_tick) begin
                m_secs <= (m_secs + 1) % 100;
                m_wrap <= (m_secs == 99);
            end else begin
                m_wrap <= 1'b0;
            end
            if (start_stop)
                m_mode <= (m_mode == M_IDLE || m_mode == M_STOP) ? M_RUN : M_STOP;
            else if (lap && m_mode == M_RUN) begin
                m_mode <= M_LAP;
                m_lap  <= m_secs;
            end else if (lap && m_mode == M_LAP)
                m_mode <= M_RUN;
        end
    end

    always @(negedge clk) begin
        logic [7:0] e_num;
        e_num = to_bcd(m_mode == M_LAP ? m_lap : m_secs);
        vectors++;
        if (num !== e_num || num[7:4] > 4'd9 || num[3:0] > 4'd9) begin
            miscompares++;
            $display("FAIL model_num: got %02h want %02h", num, e_num);
        end
        if (running !== (m_mode == M_RUN || m_mode == M_LAP)) begin
            miscompares++;
            $display("FAIL model_running: got %b want %b", running, (m_mode == M_RUN || m_mode == M_LAP));
        end
        if (lap_active !== (m_mode == M_LAP)) begin
            miscompares++;
            $display("FAIL model_lap_active: got %b want %b", lap_active, (m_mode == M_LAP));
        end
        if (wrapped !== m_wrap) begin
            miscompares++;
            $display("FAIL model_wrapped: got %b want %b", wrapped, m_wrap);
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %02h want %02h", name, act, exp);
        end
    endtask

    // Caller sits just after a falling edge; pulse is sampled by the next rising edge
    task automatic pulse(input bit ss, input bit lp, input bit cl);
        start_stop = ss;
        lap        = lp;
        clear      = cl;
        @(negedge clk);
        start_stop = 1'b0;
        lap        = 1'b0;
        clear      = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1;
        chk("rst_num", num, 8'h00);
        chk("rst_running", {7'd0, running}, 8'h00);
        @(negedge clk);
        @(negedge clk);
        #2 nrst = 1'b1;
        @(negedge clk);
        chk("idle_num", num, 8'h00);
        chk("idle_lap_active", {7'd0, lap_active}, 8'h00);

        // 1: start, first increment after 4 clocks, 10 after 40
        pulse(1, 0, 0);
        chk("start_running", {7'd0, running}, 8'h01);
        repeat (3) @(negedge clk);
        chk("pre_first_tick", num, 8'h00);
        @(negedge clk);
        chk("first_tick", num, 8'h01);
        repeat (36) @(negedge clk);
        chk("ten_seconds", num, 8'h10);

        // 2: roll over 99 -> 00
        repeat (356) @(negedge clk);
        chk("at_99", num, 8'h99);
        repeat (3) @(negedge clk);
        chk("pre_wrap_wrapped", {7'd0, wrapped}, 8'h00);
        @(negedge clk);
        chk("wrap_num", num, 8'h00);
        chk("wrap_pulse", {7'd0, wrapped}, 8'h01);
        @(negedge clk);
        chk("wrap_one_cycle", {7'd0, wrapped}, 8'h00);

        // 3: lap freeze at 05, release shows live 08
        repeat (19) @(negedge clk);
        chk("at_05", num, 8'h05);
        pulse(0, 1, 0);
        chk("lap_active", {7'd0, lap_active}, 8'h01);
        repeat (11) @(negedge clk);
        chk("lap_frozen", num, 8'h05);
        pulse(0, 1, 0);
        chk("lap_release_num", num, 8'h08);
        chk("lap_release_flag", {7'd0, lap_active}, 8'h00);

        // 4: pause mid-second, resume finishes the partial second
        pulse(1, 0, 0);
        chk("stop_running", {7'd0, running}, 8'h00);
        repeat (20) @(negedge clk);
        chk("paused_num", num, 8'h08);
        pulse(1, 0, 0);
        chk("resume_num", num, 8'h08);
        @(negedge clk);
        chk("resume_plus1", num, 8'h08);
        @(negedge clk);
        chk("resume_plus2", num, 8'h09);

        // 5: simultaneous pulses
        pulse(1, 0, 1);
        chk("clear_wins_num", num, 8'h00);
        chk("clear_wins_running", {7'd0, running}, 8'h00);
        pulse(1, 0, 0);
        pulse(1, 1, 0);
        chk("ss_beats_lap_running", {7'd0, running}, 8'h00);
        chk("ss_beats_lap_flag", {7'd0, lap_active}, 8'h00);
        pulse(0, 1, 0);
        chk("lap_ignored_stop", {7'd0, lap_active}, 8'h00);

        // 6: asynchronous reset mid-run
        pulse(1, 0, 0);
        repeat (8) @(negedge clk);
        chk("pre_reset_num", num, 8'h02);
        #2 nrst = 1'b0;
        #1;
        chk("async_num", num, 8'h00);
        chk("async_running", {7'd0, running}, 8'h00);
        chk("async_lap_active", {7'd0, lap_active}, 8'h00);
        chk("async_wrapped", {7'd0, wrapped}, 8'h00);
        @(negedge clk);
        #2 nrst = 1'b1;
        repeat (10) @(negedge clk);
        chk("post_reset_num", num, 8'h00);
        chk("post_reset_running", {7'd0, running}, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
